phys_freelist: RTL and testbench



---
 rtl/phys_freelist_pkg.sv | 29 ++
 rtl/phys_freelist_if.sv | 28 ++
 rtl/phys_freelist_multi_port_fifo.sv | 91 +++++++++
 rtl/phys_freelist.sv | 69 ++++++
 tb/tb_phys_freelist.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/phys_freelist_pkg.sv
// Shared sizing constants and types for the physical-register free list.
// Contents:
//   DISPATCH_WIDTH, PHYS_REGS, PHYS_REGS_ADDR_WIDTH, FREELIST_DEPTH and
//   derived widths; phys_addr_t / arch_addr_t; freelist_init() which builds
//   the reset image of the free list (phys ARCH_REGS..PHYS_REGS-1 in order).
package phys_freelist_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ARCH_REGS            = 32;
    localparam int ARCH_ADDR_WIDTH      = 5;
    localparam int FREELIST_DEPTH       = PHYS_REGS - ARCH_REGS;
    localparam int FREELIST_ADDR_WIDTH  = $clog2(FREELIST_DEPTH);
    localparam int FREE_COUNT_WIDTH     = FREELIST_ADDR_WIDTH + 1;

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_addr_t;
    typedef logic [ARCH_ADDR_WIDTH-1:0]      arch_addr_t;

    // Registers not covered by the identity map start out free.
    function automatic logic [FREELIST_DEPTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] freelist_init();
        logic [FREELIST_DEPTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] img;
        for (int i = 0; i < FREELIST_DEPTH; i++) begin
            img[i] = PHYS_REGS_ADDR_WIDTH'(ARCH_REGS + i);
        end
        return img;
    endfunction

endpackage

// File: rtl/phys_freelist_if.sv
// Commit / rename / committed-map-read bundle of the free list.
// master: ROB commit + rename side (drives commit_*, alloc_en, map_arch_addr)
// slave : phys_freelist (drives alloc_phys_rd, alloc_ready, free_count,
//         map_phys_rd)
interface phys_freelist_if;
    import phys_freelist_pkg::*;

    phys_addr_t [DISPATCH_WIDTH-1:0] commit_phys_rd;
    arch_addr_t [DISPATCH_WIDTH-1:0] commit_arch_rd;
    logic       [DISPATCH_WIDTH-1:0] commit_en;
    logic       [DISPATCH_WIDTH-1:0] alloc_en;
    phys_addr_t [DISPATCH_WIDTH-1:0] alloc_phys_rd;
    logic                            alloc_ready;
    logic [FREE_COUNT_WIDTH-1:0]     free_count;
    arch_addr_t                      map_arch_addr;
    phys_addr_t                      map_phys_rd;

    modport master (
        output commit_phys_rd, commit_arch_rd, commit_en, alloc_en, map_arch_addr,
        input  alloc_phys_rd, alloc_ready, free_count, map_phys_rd
    );

    modport slave (
        input  commit_phys_rd, commit_arch_rd, commit_en, alloc_en, map_arch_addr,
        output alloc_phys_rd, alloc_ready, free_count, map_phys_rd
    );

endinterface

// File: rtl/phys_freelist_multi_port_fifo.sv
// multi_port_fifo: PORTS-push / PORTS-pop circular buffer whose reset
// contents come from INIT_DATA.
// Ports:
//   clk, rst          clock, async active-high reset
//   push_en_i/data_i  per-lane push; enabled lanes pack in ascending order
//   pop_en_i          per-lane pop request
//   pop_data_o        lane i sees entry head + (enabled pop lanes below i)
//   count_o           occupancy, one bit wider than the pointers
module multi_port_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 6,
    parameter int PORTS = 2,
    parameter logic [DEPTH-1:0][WIDTH-1:0] INIT_DATA = '0,
    parameter bit INIT_FULL = 1'b1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            push_en_i,
    input  logic [PORTS-1:0][WIDTH-1:0] push_data_i,
    input  logic [PORTS-1:0]            pop_en_i,
    output logic [PORTS-1:0][WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0]            count_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            pop_cnt, push_cnt;
    logic                        pop_drop, push_drop;

    // Modulo-DEPTH add so non-power-of-two depths also wrap correctly.
    function automatic logic [PTR_W-1:0] ptr_add(logic [PTR_W-1:0] p, logic [CNT_W-1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        mem_d      = mem_q;
        pop_cnt    = '0;
        push_cnt   = '0;
        pop_drop   = 1'b0;
        push_drop  = 1'b0;
        pop_data_o = '0;
        for (int i = 0; i < PORTS; i++) begin
            pop_data_o[i] = mem_q[ptr_add(head_q, pop_cnt)];
            if (pop_en_i[i]) begin
                // Pops beyond the occupancy are refused so state stays sane.
                if (pop_cnt < count_q) pop_cnt = pop_cnt + CNT_W'(1);
                else                   pop_drop = 1'b1;
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            if (push_en_i[i]) begin
                // Slots vacated by this cycle's pops are reusable at once.
                if (int'(count_q) - int'(pop_cnt) + int'(push_cnt) < DEPTH) begin
                    mem_d[ptr_add(tail_q, push_cnt)] = push_data_i[i];
                    push_cnt = push_cnt + CNT_W'(1);
                end else begin
                    push_drop = 1'b1;
                end
            end
        end
        head_d  = ptr_add(head_q, pop_cnt);
        tail_d  = ptr_add(tail_q, push_cnt);
        count_d = count_q - pop_cnt + push_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= INIT_DATA;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= INIT_FULL ? CNT_W'(DEPTH) : '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !pop_drop);
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !push_drop);

endmodule

// File: rtl/phys_freelist.sv
// phys_freelist: committed arch->phys map plus free list of physical regs.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       phys_freelist_if.slave: commit lanes in, rename alloc lanes,
//             free_count / alloc_ready status, committed-map read port
module phys_freelist
    import phys_freelist_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    phys_freelist_if.slave  bus
);

    phys_addr_t [ARCH_REGS-1:0]      map_q, map_d;
    logic       [DISPATCH_WIDTH-1:0] push_en;
    phys_addr_t [DISPATCH_WIDTH-1:0] push_data;
    phys_addr_t [DISPATCH_WIDTH-1:0] offer;
    logic [FREE_COUNT_WIDTH-1:0]     count;

    // Working on map_d lane by lane gives lower-to-higher forwarding of the
    // old mapping and lets the highest lane win a same-arch collision.
    always_comb begin
        map_d     = map_q;
        push_en   = '0;
        push_data = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (bus.commit_en[i] && bus.commit_arch_rd[i] != '0) begin
                push_en[i]                    = 1'b1;
                push_data[i]                  = map_d[bus.commit_arch_rd[i]];
                map_d[bus.commit_arch_rd[i]]  = bus.commit_phys_rd[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PHYS_REGS_ADDR_WIDTH'(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    multi_port_fifo #(
        .DEPTH     (FREELIST_DEPTH),
        .WIDTH     (PHYS_REGS_ADDR_WIDTH),
        .PORTS     (DISPATCH_WIDTH),
        .INIT_DATA (freelist_init()),
        .INIT_FULL (1'b1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_en_i   (push_en),
        .push_data_i (push_data),
        .pop_en_i    (bus.alloc_en),
        .pop_data_o  (offer),
        .count_o     (count)
    );

    assign bus.alloc_phys_rd = offer;
    assign bus.free_count    = count;
    assign bus.alloc_ready   = (count >= FREE_COUNT_WIDTH'(DISPATCH_WIDTH));
    assign bus.map_phys_rd   = map_q[bus.map_arch_addr];

    a_alloc_when_ready: assert property (@(posedge clk) disable iff (rst)
        (|bus.alloc_en) |-> bus.alloc_ready);

endmodule

// File: tb/tb_phys_freelist.sv
module tb_phys_freelist;
    import phys_freelist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    phys_freelist_if bus ();

    phys_freelist dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO queue of free registers and a map array.
    int fq[$];
    int mmap[32];

    task automatic model_reset();
        fq.delete();
        for (int i = 32; i < 64; i++) fq.push_back(i);
        for (int i = 0; i < 32; i++) mmap[i] = i;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++)
                if (bus.alloc_en[i] && fq.size() > 0) void'(fq.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (bus.commit_en[i] && bus.commit_arch_rd[i] != 0) begin
                    fq.push_back(mmap[bus.commit_arch_rd[i]]);
                    mmap[bus.commit_arch_rd[i]] = int'(bus.commit_phys_rd[i]);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            int k;
            k = 0;
            for (int i = 0; i < 2; i++) begin
                if (k < fq.size()) chk($sformatf("offer_lane%0d", i), int'(bus.alloc_phys_rd[i]), fq[k]);
                if (bus.alloc_en[i]) k++;
            end
            chk("free_count", int'(bus.free_count), fq.size());
            chk("alloc_ready", int'(bus.alloc_ready), (fq.size() >= 2) ? 1 : 0);
            chk("map_phys_rd", int'(bus.map_phys_rd), mmap[bus.map_arch_addr]);
        end
    end

    // Apply one cycle of inputs; returns at the following negedge (pre-edge view).
    task automatic step(logic [1:0] a, logic [1:0] ce, int a0, int p0, int a1, int p1);
        @(posedge clk);
        #1;
        bus.alloc_en          = a;
        bus.commit_en         = ce;
        bus.commit_arch_rd[0] = arch_addr_t'(a0);
        bus.commit_phys_rd[0] = phys_addr_t'(p0);
        bus.commit_arch_rd[1] = arch_addr_t'(a1);
        bus.commit_phys_rd[1] = phys_addr_t'(p1);
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.alloc_en       = 2'b11;
        bus.commit_en      = 2'b00;
        bus.commit_arch_rd = '0;
        bus.commit_phys_rd = '0;
        bus.map_arch_addr  = 5'd5;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_free_count", int'(bus.free_count), 32);
        chk("rst_alloc_ready", int'(bus.alloc_ready), 1);
        chk("rst_offer0", int'(bus.alloc_phys_rd[0]), 32);
        chk("rst_offer1", int'(bus.alloc_phys_rd[1]), 33);
        chk("rst_map5", int'(bus.map_phys_rd), 5);
        bus.alloc_en = 2'b00;
        #2 rst = 1'b0;

        // Double allocation
        step(2'b11, 2'b00, 0, 0, 0, 0);
        chk("dbl_offer0", int'(bus.alloc_phys_rd[0]), 32);
        chk("dbl_offer1", int'(bus.alloc_phys_rd[1]), 33);
        idle();
        chk("dbl_count", int'(bus.free_count), 30);
        chk("dbl_head", int'(bus.alloc_phys_rd[0]), 34);
        step(2'b11, 2'b00, 0, 0, 0, 0);
        chk("dbl2_offer0", int'(bus.alloc_phys_rd[0]), 34);
        chk("dbl2_offer1", int'(bus.alloc_phys_rd[1]), 35);
        idle();
        chk("dbl2_count", int'(bus.free_count), 28);

        // Reset in the middle of operation, checked asynchronously
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", int'(bus.free_count), 32);
        chk("midrst_offer0", int'(bus.alloc_phys_rd[0]), 32);
        @(negedge clk);
        #2 rst = 1'b0;

        // Sparse allocation
        step(2'b10, 2'b00, 0, 0, 0, 0);
        chk("sparse_lane1", int'(bus.alloc_phys_rd[1]), 32);
        step(2'b11, 2'b00, 0, 0, 0, 0);
        chk("sparse_next0", int'(bus.alloc_phys_rd[0]), 33);
        chk("sparse_next1", int'(bus.alloc_phys_rd[1]), 34);

        // Single commit; map visible one cycle later
        step(2'b00, 2'b01, 5, 32, 0, 0);
        chk("commit_map_before", int'(bus.map_phys_rd), 5);
        idle();
        chk("commit_map_after", int'(bus.map_phys_rd), 32);
        chk("commit_count", int'(bus.free_count), 30);

        // Same-arch collision across lanes
        bus.map_arch_addr = 5'd7;
        step(2'b00, 2'b11, 7, 40, 7, 41);
        idle();
        chk("coll_map7", int'(bus.map_phys_rd), 41);
        chk("coll_count", int'(bus.free_count), 32);

        // Drain the whole list
        for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 0, 0, 0, 0);
        idle();
        chk("drain_count", int'(bus.free_count), 0);
        chk("drain_ready", int'(bus.alloc_ready), 0);

        // Refill two across the pointer wrap
        step(2'b00, 2'b11, 3, 50, 4, 51);
        idle();
        chk("refill_count", int'(bus.free_count), 2);
        chk("refill_ready", int'(bus.alloc_ready), 1);
        step(2'b11, 2'b00, 0, 0, 0, 0);
        chk("refill_offer0", int'(bus.alloc_phys_rd[0]), 3);
        chk("refill_offer1", int'(bus.alloc_phys_rd[1]), 4);

        // arch x0 commit is a no-op
        bus.map_arch_addr = 5'd0;
        step(2'b00, 2'b01, 0, 9, 0, 0);
        idle();
        chk("x0_count", int'(bus.free_count), 0);
        chk("x0_map", int'(bus.map_phys_rd), 0);

        // Alloc and commit in the same cycle, no commit->alloc bypass
        step(2'b00, 2'b11, 10, 20, 11, 21);
        step(2'b11, 2'b01, 12, 22, 0, 0);
        chk("both_offer0", int'(bus.alloc_phys_rd[0]), 10);
        chk("both_offer1", int'(bus.alloc_phys_rd[1]), 11);
        chk("both_count_pre", int'(bus.free_count), 2);
        bus.map_arch_addr = 5'd12;
        idle();
        chk("both_count", int'(bus.free_count), 1);
        chk("both_offer_next", int'(bus.alloc_phys_rd[0]), 12);
        chk("both_map12", int'(bus.map_phys_rd), 22);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
